// File: rtl/dac_program_ctrl.sv
// dac_program_ctrl: sequences the shadow DAC settings onto the shared 6-bit
// DAC address/data bus. For each channel it drives the address, raises the
// strobe, drives the setting, drops the strobe, then releases the bus.
// Optional feature macro: DAC_WRITE_THROUGH_EN. When defined, an idle shadow
// write launches a single-channel program sequence for the written channel.
module dac_program_ctrl #(
    parameter int unsigned NUM_CH        = 16,
    parameter int unsigned PHASE_CYC     = 1,
    parameter int unsigned DEFAULT_SIGN  = 0,
    parameter int unsigned DEFAULT_VALUE = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [5:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       sel_ext_addr,
    output logic       dac_stb,
    output logic [5:0] dac_data
);

    localparam int unsigned CH_W  = 5;
    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PH_W  = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [5:0] DEFAULT_WORD = {1'(DEFAULT_SIGN), 5'(DEFAULT_VALUE)};
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);
    localparam logic [PH_W-1:0]  LAST_PH = PH_W'(PHASE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ASTB,
        DATA,
        DSTB,
        GAP
    } state_t;

    state_t           state_q, state_n;
    logic [IDX_W-1:0] ch_q, ch_n;
    logic [PH_W-1:0]  ph_q, ph_n;
    logic             single_q, single_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             sel_q, sel_n;
    logic             stb_q, stb_n;
    logic [5:0]       data_q, data_n;

    logic [5:0]       shadow [NUM_CH];

    logic             wr_ok;
    logic             last_ph;
    logic             launch;
    logic             launch_single;
    logic [IDX_W-1:0] launch_ch;

    assign wr_ok = wr_en && (32'(wr_addr) < NUM_CH);

    // Shadow register file: host writes always land, out-of-range ones are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                shadow[i] <= DEFAULT_WORD;
            end
        end else if (wr_ok) begin
            shadow[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // State and registered bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            ph_q     <= '0;
            single_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sel_q    <= 1'b0;
            stb_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_n;
            ch_q     <= ch_n;
            ph_q     <= ph_n;
            single_q <= single_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            sel_q    <= sel_n;
            stb_q    <= stb_n;
            data_q   <= data_n;
        end
    end

    // Next state and next-cycle bus values; strobe and data change on different edges.
    always_comb begin
        state_n       = state_q;
        ch_n          = ch_q;
        ph_n          = ph_q;
        single_n      = single_q;
        busy_n        = busy_q;
        done_n        = 1'b0;
        sel_n         = sel_q;
        stb_n         = stb_q;
        data_n        = data_q;
        last_ph       = (ph_q == LAST_PH);
        launch        = 1'b0;
        launch_single = 1'b0;
        launch_ch     = '0;

        if (state_q != IDLE) begin
            ph_n = last_ph ? '0 : ph_q + PH_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!abort) begin
                    if (start) begin
                        launch = 1'b1;
                    end
`ifdef DAC_WRITE_THROUGH_EN
                    else if (wr_ok) begin
                        launch        = 1'b1;
                        launch_single = 1'b1;
                        launch_ch     = wr_addr[IDX_W-1:0];
                    end
`endif
                end
            end
            ADDR: begin
                if (last_ph) begin
                    state_n = ASTB;
                    stb_n   = 1'b1;
                end
            end
            ASTB: begin
                if (last_ph) begin
                    state_n = DATA;
                    data_n  = shadow[ch_q];
                end
            end
            DATA: begin
                if (last_ph) begin
                    state_n = DSTB;
                    stb_n   = 1'b0;
                end
            end
            DSTB: begin
                if (last_ph) begin
                    state_n = GAP;
                    sel_n   = 1'b0;
                end
            end
            GAP: begin
                if (last_ph) begin
                    if (single_q || (ch_q == LAST_CH)) begin
                        state_n  = IDLE;
                        busy_n   = 1'b0;
                        done_n   = 1'b1;
                        single_n = 1'b0;
                    end else begin
                        launch    = 1'b1;
                        launch_ch = ch_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (launch) begin
            state_n  = ADDR;
            ch_n     = launch_ch;
            ph_n     = '0;
            single_n = launch_single;
            busy_n   = 1'b1;
            sel_n    = 1'b1;
            stb_n    = 1'b0;
            data_n   = {1'b0, CH_W'(launch_ch)};
        end

        // Abort drops everything back to the reset view without a done pulse.
        if (abort && (state_q != IDLE)) begin
            state_n  = IDLE;
            ch_n     = '0;
            ph_n     = '0;
            single_n = 1'b0;
            busy_n   = 1'b0;
            done_n   = 1'b0;
            sel_n    = 1'b0;
            stb_n    = 1'b0;
            data_n   = '0;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign sel_ext_addr = sel_q;
    assign dac_stb      = stb_q;
    assign dac_data     = sel_q ? data_q : 6'bzz_zzzz;

endmodule

// File: tb/tb_dac_program_ctrl.sv
// Directed bench for dac_program_ctrl: one instance at PHASE_CYC=1 and one at
// PHASE_CYC=3 share all inputs. Honors DAC_WRITE_THROUGH_EN when defined.
module tb_dac_program_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [5:0] wr_data;

    logic       busy_a, done_a, sel_a, stb_a;
    wire  [5:0] data_a;
    logic       busy_b, done_b, sel_b, stb_b;
    wire  [5:0] data_b;

    int n_vec = 0;
    int n_err = 0;

    logic [5:0] exp_sh [16];

    localparam logic [9:0] IDLE_VEC = 10'b0000_000000;
    localparam logic [9:0] DONE_VEC = 10'b0100_000000;

    always #5 clk = ~clk;

    dac_program_ctrl #(.NUM_CH(16), .PHASE_CYC(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy_a), .done(done_a), .sel_ext_addr(sel_a),
        .dac_stb(stb_a), .dac_data(data_a)
    );

    dac_program_ctrl #(.NUM_CH(16), .PHASE_CYC(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy_b), .done(done_b), .sel_ext_addr(sel_b),
        .dac_stb(stb_b), .dac_data(data_b)
    );

    // {busy, done, sel, stb, data}; data only meaningful while the bus is driven.
    function automatic logic [9:0] obs_a();
        return {busy_a, done_a, sel_a, stb_a, (sel_a ? data_a : 6'h00)};
    endfunction

    function automatic logic [9:0] obs_b();
        return {busy_b, done_b, sel_b, stb_b, (sel_b ? data_b : 6'h00)};
    endfunction

    function automatic logic [9:0] exp_vec(input int p, input int k, input logic [5:0] v);
        logic [5:0] a;
        a = 6'(k);
        case (p)
            0:       return {4'b1010, a};
            1:       return {4'b1011, a};
            2:       return {4'b1011, v};
            3:       return {4'b1010, v};
            default: return {4'b1000, 6'h00};
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) exp_sh[i] = 6'b0_11110;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle_write(input logic [4:0] addr, input logic [5:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en = 1'b0;
        if (addr < 5'd16) exp_sh[addr[3:0]] = data;
`ifndef DAC_WRITE_THROUGH_EN
        check_eq("idle_wr_bus_quiet", obs_a(), IDLE_VEC);
`endif
        repeat (20) tick();
    endtask

    // Full sweep from a start pulse, with one optional write at cycle wcyc (<0: none).
    task automatic sweep(input string tag, input int ph, input int wcyc,
                         input logic [4:0] waddr, input logic [5:0] wdata);
        int         c;
        logic       pending;
        logic [5:0] v;
        c       = 0;
        v       = '0;
        start   = 1'b1;
        pending = 1'b0;
        if (wcyc == 0) begin
            wr_en = 1'b1; wr_addr = waddr; wr_data = wdata; pending = 1'b1;
        end
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            for (int p = 0; p < 5; p++) begin
                for (int r = 0; r < ph; r++) begin
                    c++;
                    if (p == 2 && r == 0) v = exp_sh[k];
                    if (pending) begin
                        if (waddr < 5'd16) exp_sh[waddr[3:0]] = wdata;
                        pending = 1'b0;
                    end
                    check_eq($sformatf("%s c%0d ch%0d", tag, c, k),
                             (ph == 1) ? obs_a() : obs_b(), exp_vec(p, k, v));
                    if (c == wcyc) begin
                        wr_en = 1'b1; wr_addr = waddr; wr_data = wdata; pending = 1'b1;
                    end
                    tick();
                    wr_en = 1'b0;
                end
            end
        end
        if (pending && waddr < 5'd16) exp_sh[waddr[3:0]] = wdata;
        check_eq({tag, " done"}, (ph == 1) ? obs_a() : obs_b(), DONE_VEC);
        tick();
        check_eq({tag, " idle"}, (ph == 1) ? obs_a() : obs_b(), IDLE_VEC);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; abort = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        model_reset();
        #3;
        check_eq("reset_a", obs_a(), IDLE_VEC);
        check_eq("reset_b", obs_b(), IDLE_VEC);
        do_reset();

        sweep("sweep_default", 1, -1, 5'd0, 6'h00);

        idle_write(5'd3, 6'b1_00101);
        idle_write(5'd15, 6'b0_00001);
        idle_write(5'd16, 6'b1_10101);
        sweep("sweep_custom", 1, -1, 5'd0, 6'h00);

        sweep("wr_past_data", 1, 4, 5'd0, 6'h2A);
        sweep("wr_with_start", 1, 0, 5'd6, 6'h33);
        sweep("wr_at_data_entry", 1, 12, 5'd2, 6'h07);
        sweep("wr_ahead", 1, 20, 5'd9, 6'h15);
        sweep("wr_reuse", 1, -1, 5'd0, 6'h00);

        // Start and abort together while idle: abort wins.
        do_reset();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_eq("start_abort_idle", obs_a(), IDLE_VEC);
        tick();
        check_eq("start_abort_idle2", obs_a(), IDLE_VEC);

        // Second start ignored, abort in ch4 drops the sequence silently.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (c == 11) check_eq("restart_ignored", obs_a(), exp_vec(0, 2, 6'h00));
            if (c == 22) check_eq("pre_abort", obs_a(), exp_vec(1, 4, 6'h00));
            if (c == 23) check_eq("abort_idle", obs_a(), IDLE_VEC);
            if (c == 24) check_eq("abort_no_done", obs_a(), IDLE_VEC);
            start = (c == 10);
            abort = (c == 22);
            tick();
        end
        start = 1'b0; abort = 1'b0;

        do_reset();
        sweep("sweep_ph3", 3, -1, 5'd0, 6'h00);

        // Asynchronous reset in the middle of channel 7.
        do_reset();
        idle_write(5'd7, 6'h3C);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 38; c++) tick();
        check_eq("ch7_data", obs_a(), exp_vec(2, 7, 6'h3C));
        rst = 1'b1;
        #1;
        check_eq("async_rst_a", obs_a(), IDLE_VEC);
        check_eq("async_rst_b", obs_b(), IDLE_VEC);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        sweep("after_rst", 1, -1, 5'd0, 6'h00);

        // Idle write of channel 9.
        do_reset();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 6'b1_11111;
        tick();
        wr_en = 1'b0;
`ifdef DAC_WRITE_THROUGH_EN
        for (int p = 0; p < 5; p++) begin
            check_eq($sformatf("wt_p%0d", p), obs_a(), exp_vec(p, 9, 6'b1_11111));
            tick();
        end
        check_eq("wt_done", obs_a(), DONE_VEC);
        repeat (20) tick();
`else
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("no_wt_c%0d", i), obs_a(), IDLE_VEC);
            tick();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
